compare_seq_ctrl: RTL and testbench
===================================

Name: compare_seq_ctrl

Overview:
Sequencing controller that compares two WIDTH-bit words for equality using one shared compare1b cell (y = 1 when a == b).
- Operands are latched on a start pulse and streamed MSB-first through the cell, one bit per clock.
- The scan terminates early on the first mismatch.
- Results are reported with a one-cycle done pulse.
- Sits between a requesting datapath and the existing 1-bit comparator.

Parameters:
WIDTH, 8, operand width in bits (>= 2)
IDXW, 3, width of bit-index/counter, = ceil(log2(WIDTH))

Ports:
clk      input   1       rising-edge clock
rst      input   1       asynchronous reset, active-high
start    input   1       request; sampled only in IDLE
a        input   WIDTH   operand A, captured on accepted start
b        input   WIDTH   operand B, captured on accepted start
busy     output  1       1 while in RUN or DONE
done     output  1       one-cycle pulse, result valid
eq       output  1       1 = operands equal; held until next accepted start
mis_idx  output  IDXW    index of highest mismatching bit; 0 when eq=1; held

Behaviour:
- Reset (async, rst=1): state=IDLE.
  - busy=0, done=0, eq=0, mis_idx=0.
  - Shift registers and counter cleared.
  - Takes effect immediately, including mid-RUN; the in-flight request is discarded and no done is issued.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - busy=0.
  - On start=1 at a clock edge: sa<=a, sb<=b, cnt<=WIDTH-1, eq<=0, mis_idx<=0, go to RUN.
- RUN:
  - busy=1.
  - compare1b inputs are sa[WIDTH-1] and sb[WIDTH-1] (combinational y).
  - If y=0: mis_idx<=cnt, eq<=0, go to DONE.
  - Else if cnt==0: eq<=1, mis_idx<=0, go to DONE.
  - Else: sa, sb shift left by 1 (zero fill), cnt<=cnt-1, stay in RUN.
- DONE:
  - done=1 and busy=1 for exactly one cycle; then go to IDLE unconditionally.
- start handling:
  - start in RUN or DONE is ignored; it is not queued.
  - Changes on a/b after acceptance have no effect.
  - start held high continuously: a new request is accepted on the first IDLE cycle after DONE, so back-to-back throughput is one result per (scan length + 2) cycles.
- Latency, counting from the accepting edge (edge 0):
  - Equal operands: RUN spans edges 1..WIDTH; done is high in the cycle after edge WIDTH.
  - eq, mis_idx and done update together on the same edge.
  - Highest mismatch at bit k: transition to DONE at edge WIDTH-k; done is high the following cycle.
- Width rules:
  - cnt is IDXW bits and never underflows; cnt==0 is checked before decrement.
  - Bits below the first mismatch are never examined.
- Outputs eq/mis_idx are registered, glitch-free, and stable from done until the next accepted start.

Decomposition:
- Shared include file: state encodings as localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) plus a default-width constant.
- Sub-module: instantiate the existing compare1b once for the bit comparison; no other sub-modules.
- FSM, counter and shift registers stay in compare_seq_ctrl.

Test Plan:
- WIDTH=8, a=b=8'hA5, 1-cycle start -> busy from next cycle; done after 9 cycles; eq=1, mis_idx=0; back to IDLE on the next cycle.
- a=8'h80, b=8'h00 -> mismatch at MSB; done 2 cycles after accept; eq=0, mis_idx=7.
- a=8'h01, b=8'h00 -> full scan; done 9 cycles after accept; eq=0, mis_idx=0.
- a=8'h3C, b=8'h34 (differ at bit 3) -> done 6 cycles after accept, eq=0, mis_idx=3.
  - Also pulse start and change a/b mid-RUN -> result unchanged, no second done.
- Start a=b=8'hFF, assert rst for 1 cycle at RUN cycle 4 -> busy=0, done never pulses, eq=0, mis_idx=0.
  - A new start after reset completes normally.
- start held high for 30 cycles with a=b=8'h00 -> done pulses every 10 cycles, each with eq=1; busy low exactly one cycle between requests.

Source files
------------

// File: rtl/compare_seq_ctrl_pkg.sv
// compare_seq_ctrl_pkg
//   Shared constants for the sequential equality comparator:
//   FSM state encodings, the default operand width and a small
//   helper used to size the bit-index counter.
package compare_seq_ctrl_pkg;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Default operand width
  localparam int DEF_WIDTH = 8;

  // Index width for a counter that runs from w-1 down to 0.
  // Never returns less than 1, so the counter port is always legal.
  function automatic int idx_width(input int w);
    int r;
    r = 1;
    while ((1 << r) < w) r++;
    return r;
  endfunction

endpackage

// File: rtl/compare1b.sv
// compare1b
//   Single-bit equality cell: y = 1 when a == b.
//   Ports:
//     a, b : input bits under comparison
//     y    : 1 when a equals b (combinational)
module compare1b (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = ~(a ^ b);

endmodule

// File: rtl/compare_seq_ctrl.sv
// compare_seq_ctrl
//   Compares two WIDTH-bit words for equality by streaming them MSB-first
//   through one shared compare1b cell, one bit per clock. The scan stops
//   at the first mismatching bit. Results are reported with a one-cycle
//   done pulse; eq/mis_idx are registered and held until the next
//   accepted request.
//   Ports:
//     clk     : rising-edge clock
//     rst     : asynchronous reset, active-high
//     start   : request, sampled only while idle
//     a, b    : operands, captured on an accepted start
//     busy    : high while scanning or reporting
//     done    : one-cycle pulse, result valid
//     eq      : 1 = operands equal (held)
//     mis_idx : index of highest mismatching bit, 0 when equal (held)
module compare_seq_ctrl
  import compare_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDXW  = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic [IDXW-1:0]  mis_idx
);

  localparam logic [IDXW-1:0] CNT_TOP = IDXW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb;
  logic [IDXW-1:0]  cnt;
  logic             bit_eq;

  // Decoded events for this cycle
  logic accept;    // request taken in IDLE
  logic hit_mis;   // current MSB differs
  logic hit_end;   // last bit examined and equal

  // Bit comparator sees the current MSBs of the shift registers
  compare1b u_cmp (
    .a (sa[WIDTH-1]),
    .b (sb[WIDTH-1]),
    .y (bit_eq)
  );

  assign accept  = (state == IDLE) && start;
  assign hit_mis = (state == RUN) && !bit_eq;
  assign hit_end = (state == RUN) && bit_eq && (cnt == '0);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (hit_mis || hit_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Moore outputs straight from the state register, so busy/done
  // are glitch-free.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // ---------------- Datapath: shift registers + counter ----------------
  // cnt tracks the original bit index of the current MSB. It is tested
  // for zero before any decrement, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sa  <= a;
      sb  <= b;
      cnt <= CNT_TOP;
    end else if (state == RUN && bit_eq && cnt != '0) begin
      sa  <= {sa[WIDTH-2:0], 1'b0};
      sb  <= {sb[WIDTH-2:0], 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

  // ---------------- Result registers ----------------
  // Cleared on acceptance, written on the RUN->DONE edge (same edge
  // the done pulse begins), otherwise held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eq      <= 1'b0;
      mis_idx <= '0;
    end else if (accept) begin
      eq      <= 1'b0;
      mis_idx <= '0;
    end else if (hit_mis) begin
      eq      <= 1'b0;
      mis_idx <= cnt;
    end else if (hit_end) begin
      eq      <= 1'b1;
      mis_idx <= '0;
    end
  end

endmodule

// File: tb/tb_compare_seq_ctrl.sv
// tb_compare_seq_ctrl
//   Directed and randomized checks of compare_seq_ctrl (WIDTH=8) against
//   a transaction-level model: the expected result and latency of each
//   request are derived from the highest differing bit of the operands.
module tb_compare_seq_ctrl;

  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          busy, done, eq;
  logic [IW-1:0] mis_idx;

  int n_chk  = 0;
  int n_fail = 0;

  compare_seq_ctrl #(.WIDTH(W), .IDXW(IW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .eq      (eq),
    .mis_idx (mis_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Highest differing bit, or -1 when the words are equal.
  function automatic int top_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    for (int i = W - 1; i >= 0; i--)
      if (x[i] != y[i]) return i;
    return -1;
  endfunction

  // Issue one request (called just after a rising edge) and follow it
  // cycle by cycle. While it runs, the operands are scrambled and a stray
  // start is pulsed, neither of which may affect the outcome.
  task automatic run_req(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb);
    int k, n;
    logic          exp_eq;
    logic [IW-1:0] exp_idx;
    k       = top_diff(va, vb);
    exp_eq  = (k < 0);
    exp_idx = (k < 0) ? '0 : IW'(k);
    n       = (k < 0) ? W : W - k;   // edges from accept to entering DONE
    a = va; b = vb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, " busy@accept"}, busy, 1);
    check({tag, " done@accept"}, done, 0);
    check({tag, " eq clr"}, eq, 0);
    check({tag, " idx clr"}, mis_idx, 0);
    a = W'($urandom); b = W'($urandom);
    for (int j = 1; j <= n; j++) begin
      start = (j == 2 && n >= 3);
      @(posedge clk); #1;
      if (j < n) begin
        check({tag, " done early"}, done, 0);
        check({tag, " busy run"}, busy, 1);
      end else begin
        check({tag, " done"}, done, 1);
        check({tag, " busy done"}, busy, 1);
        check({tag, " eq"}, eq, exp_eq);
        check({tag, " mis_idx"}, mis_idx, exp_idx);
      end
    end
    start = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      check({tag, " idle busy"}, busy, 0);
      check({tag, " no 2nd done"}, done, 0);
      check({tag, " eq held"}, eq, exp_eq);
      check({tag, " idx held"}, mis_idx, exp_idx);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;

    // Reset state
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst eq", eq, 0);
    check("rst idx", mis_idx, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Directed cases
    run_req("eq_A5", 8'hA5, 8'hA5);
    run_req("msb", 8'h80, 8'h00);
    run_req("lsb", 8'h01, 8'h00);
    run_req("bit3", 8'h3C, 8'h34);

    // Reset in the middle of a scan: eq was 1 just before
    run_req("eq_pre", 8'h5A, 8'h5A);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin @(posedge clk); #1; end
    check("mid busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async busy", busy, 0);
    check("async done", done, 0);
    check("async eq", eq, 0);
    check("async idx", mis_idx, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(posedge clk); #1;
      check("post-rst done", done, 0);
      check("post-rst busy", busy, 0);
    end
    check("post-rst eq", eq, 0);
    run_req("after_rst", 8'hFF, 8'hFF);

    // Randomized requests: equal, single-bit-flip and arbitrary pairs
    for (int t = 0; t < 24; t++) begin
      ra = W'($urandom);
      case (t % 3)
        0:       rb = ra;
        1:       rb = ra ^ W'(1 << $urandom_range(W - 1, 0));
        default: rb = W'($urandom);
      endcase
      run_req("rand", ra, rb);
    end

    // start held high: one result every W+2 cycles, busy low one cycle between
    a = '0; b = '0; start = 1'b1;
    for (int e = 0; e < 30; e++) begin
      @(posedge clk); #1;
      check("held done", done, (e % (W + 2)) == W);
      check("held busy", busy, (e % (W + 2)) != W + 1);
      if ((e % (W + 2)) == W) check("held eq", eq, 1);
    end
    start = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
